// File: rtl/regfile_writeback.sv
// Y86-64 register file with integrated E/M writeback, retire counter and conflict flag.
// Optional same-cycle write-through reads when REGFILE_BYPASS_EN is defined.
module regfile_writeback #(
    parameter int unsigned DATA_W   = 64,
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [DATA_W-1:0] rsp,
    output logic [31:0]       retire_cnt,
    output logic              wr_conflict
);

    localparam int unsigned NREG       = 15;
    localparam int unsigned CNT_W      = 32;
    localparam logic [3:0]  REG_NONE   = 4'hF;
    localparam logic [3:0]  ICODE_CMOV = 4'h2;
    localparam int unsigned RSP_IDX    = 4;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              conflict_q, conflict_d;
    logic [3:0]        dste_eff_c;

    // A not-taken conditional move drops its E-port write.
    always_comb begin
        dste_eff_c = dstE;
        if (icode == ICODE_CMOV && !cnd) begin
            dste_eff_c = REG_NONE;
        end
    end

    // Writeback: M port is applied after E so it wins on a shared destination.
    always_comb begin
        regs_d     = regs_q;
        cnt_d      = cnt_q;
        conflict_d = 1'b0;
        if (wr_en) begin
            cnt_d      = cnt_q + CNT_W'(1);
            conflict_d = (dste_eff_c == dstM) && (dstM != REG_NONE);
            for (int i = 0; i < NREG; i++) begin
                if (dste_eff_c == 4'(i)) begin
                    regs_d[i] = valE;
                end
                if (dstM == 4'(i)) begin
                    regs_d[i] = valM;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == RSP_IDX) ? DATA_W'(RSP_INIT) : '0;
            end
            cnt_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
        end
    end

    // Read ports; selector F matches no register and reads zero.
    always_comb begin
        valA = '0;
        valB = '0;
        for (int i = 0; i < NREG; i++) begin
            if (srcA == 4'(i)) begin
                valA = regs_q[i];
            end
            if (srcB == 4'(i)) begin
                valB = regs_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && srcA != REG_NONE) begin
            if (srcA == dste_eff_c) valA = valE;
            if (srcA == dstM)       valA = valM;
        end
        if (wr_en && srcB != REG_NONE) begin
            if (srcB == dste_eff_c) valB = valE;
            if (srcB == dstM)       valB = valM;
        end
`endif
    end

    assign rsp         = regs_q[RSP_IDX];
    assign retire_cnt  = cnt_q;
    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized traffic vs. a reference model.
module tb_regfile_writeback;

    localparam int unsigned DATA_W = 64;
    localparam logic [63:0] RSP_INIT = 64'h100;
    localparam logic [3:0]  NONE = 4'hF;

    logic              clk = 1'b0;
    logic              run = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [3:0]        icode;
    logic              cnd;
    logic [3:0]        dstE, dstM, srcA, srcB;
    logic [DATA_W-1:0] valE, valM;
    logic [DATA_W-1:0] valA, valB, rsp;
    logic [31:0]       retire_cnt;
    logic              wr_conflict;

    // Reference model state
    logic [DATA_W-1:0] ref_r [15];
    logic [31:0]       ref_cnt;
    logic              ref_conf;

    int pass_cnt = 0;
    int total    = 0;

    regfile_writeback #(.DATA_W(DATA_W), .RSP_INIT(RSP_INIT)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .icode(icode), .cnd(cnd),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB), .rsp(rsp),
        .retire_cnt(retire_cnt), .wr_conflict(wr_conflict)
    );

    initial forever begin
        #5;
        if (run) clk = ~clk;
    end

    function automatic void model_reset();
        for (int i = 0; i < 15; i++) ref_r[i] = '0;
        ref_r[4] = RSP_INIT;
        ref_cnt  = 0;
        ref_conf = 1'b0;
    endfunction

    function automatic logic [3:0] eff_dst();
        return (icode == 4'h2 && cnd == 1'b0) ? NONE : dstE;
    endfunction

    function automatic logic [DATA_W-1:0] stored(input logic [3:0] s);
        return (s == NONE) ? '0 : ref_r[s];
    endfunction

    // Value a read port should show during the current cycle.
    function automatic logic [DATA_W-1:0] exp_read(input logic [3:0] s);
`ifdef REGFILE_BYPASS_EN
        if (wr_en && s != NONE && s == dstM) return valM;
        if (wr_en && s != NONE && s == eff_dst()) return valE;
`endif
        return stored(s);
    endfunction

    function automatic void model_edge();
        logic [3:0] e;
        e = eff_dst();
        if (wr_en) begin
            if (e != NONE) ref_r[e] = valE;
            if (dstM != NONE) ref_r[dstM] = valM;
            ref_cnt  = ref_cnt + 1;
            ref_conf = (e == dstM) && (dstM != NONE);
        end else begin
            ref_conf = 1'b0;
        end
    endfunction

    task automatic drive(input logic w, input logic [3:0] ic, input logic c,
                         input logic [3:0] de, input logic [DATA_W-1:0] ve,
                         input logic [3:0] dm, input logic [DATA_W-1:0] vm);
        wr_en = w; icode = ic; cnd = c; dstE = de; valE = ve; dstM = dm; valM = vm;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 1'b0, NONE, '0, NONE, '0);
    endtask

    task automatic test_reset();
        idle();
        srcA = 4'h0; srcB = 4'h4;
        rst_n = 1'b1; #3; rst_n = 1'b0; #3;
        model_reset();
        if (rsp !== 64'h100) begin $display("FAIL reset_rsp got=%h exp=%h", rsp, 64'h100); end else pass_cnt++;
        total++;
        if (valA !== 64'h0) begin $display("FAIL reset_valA got=%h exp=0", valA); end else pass_cnt++;
        total++;
        if (valB !== 64'h100) begin $display("FAIL reset_valB got=%h exp=%h", valB, 64'h100); end else pass_cnt++;
        total++;
        if (retire_cnt !== 32'd0 || wr_conflict !== 1'b0) begin
            $display("FAIL reset_cnt got=%0d/%b exp=0/0", retire_cnt, wr_conflict);
        end else pass_cnt++;
        total++;
        #3; rst_n = 1'b1; #3;
        run = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_write();
        drive(1'b1, 4'h6, 1'b0, 4'h3, 64'h5, NONE, '0);
        tick();
        idle();
        srcA = 4'h3;
        #1;
        if (valA !== 64'h5) begin $display("FAIL basic_valA got=%h exp=5", valA); end else pass_cnt++;
        total++;
        if (retire_cnt !== 32'd1) begin $display("FAIL basic_cnt got=%0d exp=1", retire_cnt); end else pass_cnt++;
        total++;
    endtask

    task automatic test_cmov();
        srcA = 4'h1;
        drive(1'b1, 4'h2, 1'b0, 4'h1, 64'h7, NONE, '0);
        tick();
        idle(); #1;
        if (valA !== 64'h0) begin $display("FAIL cmov_nt got=%h exp=0", valA); end else pass_cnt++;
        total++;
        drive(1'b1, 4'h2, 1'b1, 4'h1, 64'h7, NONE, '0);
        tick();
        idle(); #1;
        if (valA !== 64'h7) begin $display("FAIL cmov_t got=%h exp=7", valA); end else pass_cnt++;
        total++;
    endtask

    task automatic test_popq_conflict();
        drive(1'b1, 4'hB, 1'b0, 4'h4, 64'h108, 4'h4, 64'hAA);
        tick();
        idle(); #1;
        if (rsp !== 64'hAA) begin $display("FAIL popq_rsp got=%h exp=aa", rsp); end else pass_cnt++;
        total++;
        if (wr_conflict !== 1'b1) begin $display("FAIL popq_conf1 got=%b exp=1", wr_conflict); end else pass_cnt++;
        total++;
        tick();
        if (wr_conflict !== 1'b0) begin $display("FAIL popq_conf2 got=%b exp=0", wr_conflict); end else pass_cnt++;
        total++;
    endtask

    task automatic test_read_during_write();
        logic [DATA_W-1:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 64'h9;
`else
        exp_same = 64'h0;
`endif
        srcB = 4'h2;
        drive(1'b1, 4'h6, 1'b0, 4'h2, 64'h9, NONE, '0);
        #1;
        if (valB !== exp_same) begin $display("FAIL rdw_same got=%h exp=%h", valB, exp_same); end else pass_cnt++;
        total++;
        tick();
        idle(); #1;
        if (valB !== 64'h9) begin $display("FAIL rdw_next got=%h exp=9", valB); end else pass_cnt++;
        total++;
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] ea, eb;
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 11)), 1'($urandom),
                  4'($urandom_range(0, 15)), {$urandom, $urandom},
                  4'($urandom_range(0, 15)), {$urandom, $urandom});
            srcA = 4'($urandom_range(0, 15));
            srcB = 4'($urandom_range(0, 15));
            #1;
            ea = exp_read(srcA);
            eb = exp_read(srcB);
            if (valA !== ea) begin $display("FAIL rnd_valA n=%0d src=%0d got=%h exp=%h", n, srcA, valA, ea); end else pass_cnt++;
            total++;
            if (valB !== eb) begin $display("FAIL rnd_valB n=%0d src=%0d got=%h exp=%h", n, srcB, valB, eb); end else pass_cnt++;
            total++;
            tick();
            if (rsp !== ref_r[4]) begin $display("FAIL rnd_rsp n=%0d got=%h exp=%h", n, rsp, ref_r[4]); end else pass_cnt++;
            total++;
            if (retire_cnt !== ref_cnt) begin $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, retire_cnt, ref_cnt); end else pass_cnt++;
            total++;
            if (wr_conflict !== ref_conf) begin $display("FAIL rnd_conf n=%0d got=%b exp=%b", n, wr_conflict, ref_conf); end else pass_cnt++;
            total++;
        end
        idle();
        for (int r = 0; r < 15; r++) begin
            srcA = 4'(r);
            #1;
            if (valA !== ref_r[r]) begin $display("FAIL rnd_final r=%0d got=%h exp=%h", r, valA, ref_r[r]); end else pass_cnt++;
            total++;
        end
        srcA = NONE;
        #1;
        if (valA !== 64'h0) begin $display("FAIL src_none got=%h exp=0", valA); end else pass_cnt++;
        total++;
    endtask

    task automatic test_reset_midrun();
        drive(1'b1, 4'h6, 1'b0, 4'h5, 64'h33, NONE, '0);
        tick();
        idle();
        srcA = 4'h5;
        #1;
        if (valA !== 64'h33) begin $display("FAIL mid_pre got=%h exp=33", valA); end else pass_cnt++;
        total++;
        rst_n = 1'b0;
        model_reset();
        #1;
        if (valA !== 64'h0) begin $display("FAIL mid_r5 got=%h exp=0", valA); end else pass_cnt++;
        total++;
        if (retire_cnt !== 32'd0 || rsp !== 64'h100) begin
            $display("FAIL mid_state got=%0d/%h exp=0/100", retire_cnt, rsp);
        end else pass_cnt++;
        total++;
        // Write held across an edge while reset is asserted must be discarded.
        drive(1'b1, 4'h6, 1'b0, 4'h5, 64'h44, NONE, '0);
        @(posedge clk); #1;
        if (valA !== 64'h0) begin $display("FAIL mid_discard got=%h exp=0", valA); end else pass_cnt++;
        total++;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'h6, 1'b0, 4'h5, 64'h55, NONE, '0);
        tick();
        idle(); #1;
        if (valA !== 64'h55 || retire_cnt !== 32'd1) begin
            $display("FAIL mid_first got=%h/%0d exp=55/1", valA, retire_cnt);
        end else pass_cnt++;
        total++;
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_cmov();
        test_popq_conflict();
        test_read_during_write();
        test_random();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
